oam_dma_ctrl: RTL

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/nes_mem_pkg.sv | 32 +++
 rtl/oam_dma_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nes_mem_pkg.sv
// -----------------------------------------------------------------------------
// nes_mem_pkg
// Shared definitions for the NES memory-side blocks:
//   - default CPU address of the sprite DMA trigger register
//   - default address of the sprite-RAM data port
//   - state encoding of the sprite DMA controller
//   - helper that tells whether a DMA state holds the CPU off the bus
// -----------------------------------------------------------------------------
package nes_mem_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DUMMY = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  // True for every state in which the DMA owns the memory bus.
  function automatic logic is_transfer_state(input dma_state_e st);
    logic res;
    case (st)
      DUMMY, ALIGN, READ, WRITE: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite (OAM) DMA controller sitting between the CPU core and the memory
// controller. A CPU write to DMA_REG_ADDR latches a source page and copies the
// 256 bytes {page,00}..{page,FF} to the sprite-RAM data port OAM_DATA_ADDR as
// alternating READ/WRITE cycles while the core is stalled. Outside a transfer
// the core bus is passed straight through.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   core_addr/wdata     : core bus address / write data
//   core_write_en/read_en: core bus strobes
//   core_rdata          : read data returned to the core (always mem_rdata)
//   core_stall          : core holds its state while high
//   mem_addr/wdata      : bus towards the memory controller
//   mem_write_en/read_en: memory strobes
//   mem_rdata           : memory read data (one-cycle latency)
//   dma_busy            : transfer in progress
//   dma_done            : one-cycle pulse after the last WRITE
// -----------------------------------------------------------------------------
module oam_dma_ctrl
  import nes_mem_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  input  logic        core_write_en,
  input  logic        core_read_en,
  output logic [7:0]  core_rdata,
  output logic        core_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy,
  output logic        dma_done
);

  dma_state_e  state_r;
  dma_state_e  state_s;
  logic [7:0]  page_r;
  logic [7:0]  idx_r;
  logic        parity_r;
  logic        busy_r;
  logic        done_r;
  logic        trigger_s;
  logic        last_s;

  assign trigger_s  = core_write_en && (core_addr == DMA_REG_ADDR);
  assign last_s     = (idx_r == 8'hFF);

  assign core_rdata = mem_rdata;
  assign core_stall = busy_r;
  assign dma_busy   = busy_r;
  assign dma_done   = done_r;

  // State register, byte counter, cycle parity and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      page_r   <= 8'h00;
      idx_r    <= 8'h00;
      parity_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      parity_r <= ~parity_r;
      // busy tracks the state being entered, so it is high exactly while
      // the controller sits in a transfer state.
      busy_r   <= is_transfer_state(state_s);
      done_r   <= (state_r == WRITE) && last_s;
      if ((state_r == IDLE) && trigger_s) begin
        page_r <= core_wdata;
        idx_r  <= 8'h00;
      end else if (state_r == WRITE) begin
        // Wraps to 0 on the final byte; the FSM leaves the loop instead.
        idx_r  <= idx_r + 8'd1;
      end
    end
  end

  // Next-state logic and memory bus mux (pass-through only in IDLE).
  always_comb begin
    state_s      = state_r;
    mem_addr     = 16'h0000;
    mem_wdata    = 8'h00;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state_r)
      IDLE: begin
        mem_addr     = core_addr;
        mem_wdata    = core_wdata;
        mem_write_en = core_write_en;
        mem_read_en  = core_read_en;
        if (trigger_s) begin
          state_s = DUMMY;
        end else begin
          state_s = IDLE;
        end
      end
      DUMMY: begin
        // An odd-parity DUMMY inserts ALIGN so every READ lands on the
        // same cycle parity.
        if (parity_r) begin
          state_s = ALIGN;
        end else begin
          state_s = READ;
        end
      end
      ALIGN: begin
        state_s = READ;
      end
      READ: begin
        mem_addr    = {page_r, idx_r};
        mem_read_en = 1'b1;
        state_s     = WRITE;
      end
      WRITE: begin
        // The byte fetched in READ arrives on mem_rdata during this cycle.
        mem_addr     = OAM_DATA_ADDR;
        mem_wdata    = mem_rdata;
        mem_write_en = 1'b1;
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = READ;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule
